// File: rtl/mul_iter_ctrl.sv
// mul_iter_ctrl: iterative shift-add multiply sequencer for the EX stage.
// Latency: capture cycle + N=32/STEP_BITS BUSY cycles + 1 DONE cycle (N+2 in EX).
// Backpressure: stall_o holds PC, IF/ID and ID/EX until the DONE cycle; flush_i aborts.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   valid_i               mul instruction present in EX
//   data1_i, data2_i      multiplicand / multiplier, sampled on capture only
//   flush_i               abort current op, return to IDLE
//   stall_o               combinational pipeline freeze request
//   done_o                single-cycle result-valid pulse
//   data_o                low 32 bits of the product (accumulator register)
//
// Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero (at least one BUSY cycle is always taken).

module mul_iter_ctrl #(
  parameter int STEP_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] data_o
);

  localparam int N  = 32 / STEP_BITS;
  localparam int CW = 6;

  generate
    if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 4 || STEP_BITS == 8)) begin : g_bad_step
      $error("mul_iter_ctrl: STEP_BITS must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     mcand;
  logic [31:0]     mplier;
  logic [31:0]     acc;
  logic [31:0]     digit;
  logic [31:0]     mplier_shift;
  logic            last_step;

  // Low STEP_BITS multiplier bits, zero-extended; the partial product is
  // truncated to 32 bits, which is all the result ever needs.
  assign digit        = {{(32-STEP_BITS){1'b0}}, mplier[STEP_BITS-1:0]};
  assign mplier_shift = mplier >> STEP_BITS;

`ifdef MUL_EARLY_EXIT_EN
  // Nothing left to add once the shifted multiplier is zero.
  assign last_step = (cnt == CW'(N-1)) || (mplier_shift == 32'd0);
`else
  assign last_step = (cnt == CW'(N-1));
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // Datapath and step counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (flush_i) begin
      // acc keeps its partial value; it is meaningless after an abort.
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc + mcand * digit;
          mcand  <= mcand << STEP_BITS;
          mplier <= mplier_shift;
          cnt    <= cnt + CW'(1);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Outputs. Stall is high in the capture cycle so the mul stays in EX, and
  // drops in DONE so the pipeline latches the result that same cycle.
  always_comb begin
    stall_o = rst_i & ~flush_i & valid_i & (state != DONE);
    done_o  = rst_i & ~flush_i & (state == DONE);
    data_o  = acc;
  end

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// tb_mul_iter_ctrl: directed bench for mul_iter_ctrl at STEP_BITS=1 and STEP_BITS=4.
// Cycle T0 is the capture cycle; outputs are sampled on the falling edge.
// Inputs change 1 time unit after the rising edge.

module tb_mul_iter_ctrl;

  logic        clk;
  logic        rst;
  logic        v1, f1, s1, d1;
  logic [31:0] a1, b1, q1;
  logic        v4, f4, s4, d4;
  logic [31:0] a4, b4, q4;

  int tests;
  int fails;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  mul_iter_ctrl #(.STEP_BITS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .data1_i(a1), .data2_i(b1),
    .flush_i(f1), .stall_o(s1), .done_o(d1), .data_o(q1)
  );

  mul_iter_ctrl #(.STEP_BITS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .data1_i(a4), .data2_i(b4),
    .flush_i(f4), .stall_o(s4), .done_o(d4), .data_o(q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one op from T0 and measures it; returns at the start of the cycle
  // after the done pulse (or after the cycle budget, with dcyc = -1).
  task automatic do_op(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                       output int dcyc, output logic [31:0] val, output int nstall);
    dcyc   = -1;
    val    = '0;
    nstall = 0;
    if (sel4) begin v4 = 1'b1; a4 = a; b4 = b; end
    else      begin v1 = 1'b1; a1 = a; b1 = b; end
    for (int k = 0; k < 60 && dcyc < 0; k++) begin
      @(negedge clk);
      if (sel4 ? s4 : s1) nstall++;
      if (sel4 ? d4 : d1) begin
        dcyc = k;
        val  = sel4 ? q4 : q1;
      end
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; v1 = 1'b1; v4 = 1'b1; f1 = 1'b0; f4 = 1'b0;
    a1 = 32'd7; b1 = 32'd6; a4 = 32'd7; b4 = 32'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (s1 !== 1'b0 || d1 !== 1'b0 || q1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_x1: stall=%b done=%b data=%h, want 0 0 00000000", s1, d1, q1);
    end
    tests++;
    if (s4 !== 1'b0 || d4 !== 1'b0 || q4 !== 32'd0) begin
      fails++;
      $display("FAIL reset_x4: stall=%b done=%b data=%h, want 0 0 00000000", s4, d4, q4);
    end
    @(posedge clk); #1;
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, ns;
    logic [31:0] val;
    do_op(1'b0, 32'd7, 32'd6, dc, val, ns);
    tests++;
    if (dc !== (EE ? 4 : 33) || val !== 32'h0000002A) begin
      fails++;
      $display("FAIL mul_7x6: done at T%0d data=%h, want T%0d 0000002a", dc, val, EE ? 4 : 33);
    end
    tests++;
    if (ns !== dc) begin
      fails++;
      $display("FAIL stall_7x6: stall cycles=%0d, want %0d", ns, dc);
    end
    @(negedge clk);
    tests++;
    if (d1 !== 1'b0 || q1 !== 32'h0000002A) begin
      fails++;
      $display("FAIL done_pulse: done=%b data=%h after DONE, want 0 0000002a", d1, q1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int dc, ns;
    logic [31:0] val;
    do_op(1'b0, 32'hFFFFFFFD, 32'd5, dc, val, ns);
    tests++;
    if (dc !== (EE ? 4 : 33) || val !== 32'hFFFFFFF1) begin
      fails++;
      $display("FAIL signed: done at T%0d data=%h, want T%0d fffffff1", dc, val, EE ? 4 : 33);
    end
  endtask

  task automatic test_overflow();
    int dc, ns;
    logic [31:0] val;
    do_op(1'b0, 32'h00010000, 32'h00010000, dc, val, ns);
    tests++;
    if (dc !== (EE ? 18 : 33) || val !== 32'h00000000) begin
      fails++;
      $display("FAIL ovf_x1: done at T%0d data=%h, want T%0d 00000000", dc, val, EE ? 18 : 33);
    end
    do_op(1'b1, 32'h00010000, 32'h00010000, dc, val, ns);
    tests++;
    if (dc !== (EE ? 6 : 9) || val !== 32'h00000000) begin
      fails++;
      $display("FAIL ovf_x4: done at T%0d data=%h, want T%0d 00000000", dc, val, EE ? 6 : 9);
    end
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, val, ns);
    tests++;
    if (dc !== 9 || val !== 32'h00000001 || ns !== 9) begin
      fails++;
      $display("FAIL allones_x4: done at T%0d data=%h stalls=%0d, want T9 00000001 9", dc, val, ns);
    end
  endtask

  task automatic test_flush();
    int dc, ns, seen_done;
    logic [31:0] val;
    seen_done = 0;
    v1 = 1'b1; a1 = 32'd123; b1 = 32'd456;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (d1) seen_done++;
      @(posedge clk); #1;
    end
    f1 = 1'b1;
    @(negedge clk);
    tests++;
    if (s1 !== 1'b0 || d1 !== 1'b0) begin
      fails++;
      $display("FAIL flush_t5: stall=%b done=%b, want 0 0", s1, d1);
    end
    @(posedge clk); #1;
    f1 = 1'b0;
    // T6: the block must already be in IDLE, so this is the next capture.
    do_op(1'b0, 32'd2, 32'd3, dc, val, ns);
    tests++;
    if (seen_done != 0 || dc !== (EE ? 3 : 33) || val !== 32'd6) begin
      fails++;
      $display("FAIL flush_next: early dones=%0d done at T%0d data=%h, want 0 T%0d 00000006",
               seen_done, dc, val, EE ? 3 : 33);
    end
  endtask

  task automatic test_back_to_back();
    int dc, ns;
    logic [31:0] val;
    v1 = 1'b1; a1 = 32'd100; b1 = 32'h80000000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (s1 !== 1'b0 || d1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_t10: stall=%b done=%b, want 0 0", s1, d1);
    end
    @(posedge clk); #1;
    rst = 1'b1; v1 = 1'b0;
    @(negedge clk);
    tests++;
    if (s1 !== 1'b0 || d1 !== 1'b0 || q1 !== 32'd0) begin
      fails++;
      $display("FAIL rst_t11: stall=%b done=%b data=%h, want 0 0 00000000", s1, d1, q1);
    end
    @(posedge clk); #1;
    do_op(1'b0, 32'd3, 32'd3, dc, val, ns);
    tests++;
    if (dc !== (EE ? 3 : 33) || val !== 32'd9) begin
      fails++;
      $display("FAIL b2b_first: done at T%0d data=%h, want T%0d 00000009", dc, val, EE ? 3 : 33);
    end
    // Starts in the cycle right after DONE: a single IDLE/capture cycle.
    do_op(1'b0, 32'd4, 32'd4, dc, val, ns);
    tests++;
    if (dc !== (EE ? 4 : 33) || val !== 32'd16 || ns !== dc) begin
      fails++;
      $display("FAIL b2b_second: done at T%0d data=%h stalls=%0d, want T%0d 00000010 %0d",
               dc, val, ns, EE ? 4 : 33, EE ? 4 : 33);
    end
  endtask

  task automatic test_early_exit();
    int dc, ns;
    logic [31:0] val;
    do_op(1'b0, 32'h00001234, 32'd1, dc, val, ns);
    tests++;
    if (dc !== (EE ? 2 : 33) || val !== 32'h00001234) begin
      fails++;
      $display("FAIL ee_x1: done at T%0d data=%h, want T%0d 00001234", dc, val, EE ? 2 : 33);
    end
    do_op(1'b0, 32'd5, 32'h80000000, dc, val, ns);
    tests++;
    if (dc !== 33 || val !== 32'h80000000) begin
      fails++;
      $display("FAIL ee_msb: done at T%0d data=%h, want T33 80000000", dc, val);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    v1 = 1'b0; v4 = 1'b0; f1 = 1'b0; f4 = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_early_exit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
